// File: rtl/bid_pkg.sv
// ============================================================================
//  Module  : bid_pkg
//  Brief   : Shared types and arbiter address map for the bus-master agent.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } bm_state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bid;
  } cmd_t;

  // Arbiter address map: FFEF_<slave>2<master>0
  function automatic logic [31:0] slave_addr(input logic [3:0] slv, input logic [3:0] mst);
    return {16'hFFEF, slv, 4'h2, mst, 4'h0};
  endfunction

  localparam logic [31:0] C_M0_S0 = 32'hFFEF_0200;
  localparam logic [31:0] C_M0_S1 = 32'hFFEF_1200;
  localparam logic [31:0] C_M0_S2 = 32'hFFEF_2200;
  localparam logic [31:0] C_M0_S3 = 32'hFFEF_3200;

endpackage

`default_nettype wire

// File: rtl/bid_cmd_fifo.sv
// ============================================================================
//  Module  : bid_cmd_fifo
//  Brief   : Show-ahead synchronous command FIFO with full/empty flags.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bid_cmd_fifo
  import bid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bid_master_ctrl.sv
// ============================================================================
//  Module  : bid_master_ctrl
//  Brief   : Master-side bus agent: queues commands, bids for the arbiter,
//            performs the transfer and returns one response per command.
//            Optional bid escalation enabled by defining BID_ESCALATE_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bid_master_ctrl
  import bid_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BID_W    = 32,
  parameter int XFER_CYC = 2,
  parameter int ESC_INT  = 8,
  parameter int ESC_STEP = 4,
  parameter int BID_MAX  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BID_W-1:0]  cmd_bid,
  output logic              xfr,
  output logic [BID_W-1:0]  req,
  input  logic              grant,
  output logic [ADDR_W-1:0] addr,
  output logic              RW,
  output logic [DATA_W-1:0] DataToSlave,
  input  logic [DATA_W-1:0] DataFromSlave,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        rsp_retry
);

  localparam int CW = 1 + ADDR_W + DATA_W + BID_W;
  localparam int HW = (XFER_CYC > 1) ? $clog2(XFER_CYC) : 1;

  bm_state_t         state_q, state_d;
  logic [CW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, pop, push;
  logic              h_rw;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [BID_W-1:0]  h_bid;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [BID_W-1:0]  bid_q;
  logic [7:0]        retry_q;
  logic [HW-1:0]     hold_q;
  logic              hold_last;

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full || pop;
  assign push      = cmd_valid && cmd_ready;
  assign hold_last = (int'(hold_q) == XFER_CYC - 1);
  assign {h_rw, h_addr, h_wdata, h_bid} = fifo_rdata;

  bid_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({cmd_rw, cmd_addr, cmd_wdata, cmd_bid}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BID_ESCALATE_EN
  localparam logic [BID_W:0] BID_CAP = (BID_W+1)'(BID_MAX);
  logic [7:0]       wait_q;
  logic             esc_tick;
  logic [BID_W:0]   bid_sum;
  logic [BID_W-1:0] bid_esc;

  assign esc_tick = (state_q == REQ) && (wait_q != 8'hFF) && (((int'(wait_q) + 1) % ESC_INT) == 0);
  assign bid_sum  = {1'b0, bid_q} + (BID_W+1)'(ESC_STEP);
  assign bid_esc  = (bid_sum > BID_CAP) ? BID_CAP[BID_W-1:0] : bid_sum[BID_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || pop) begin
      wait_q <= '0;
    end else if (state_q == REQ && wait_q != 8'hFF) begin
      wait_q <= wait_q + 8'd1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    xfr         = 1'b0;
    req         = '0;
    addr        = '0;
    RW          = 1'b0;
    DataToSlave = '0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_retry   = '0;
    if (state_q == REQ || state_q == XFER) begin
      xfr         = 1'b1;
      req         = bid_q;
      addr        = addr_q;
      RW          = rw_q;
      DataToSlave = wdata_q;
    end
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = REQ;
      REQ:  if (grant) state_d = XFER;
      XFER: begin
        if (!grant)         state_d = REQ;
        else if (hold_last) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_retry = retry_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bid_q   <= '0;
      retry_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (pop) begin
          rw_q    <= h_rw;
          addr_q  <= h_addr;
          wdata_q <= h_wdata;
          // A zero bid would look like "no request" to the arbiter.
          bid_q   <= (h_bid == '0) ? {{(BID_W-1){1'b0}}, 1'b1} : h_bid;
          rdata_q <= '0;
          retry_q <= '0;
        end
        REQ: begin
          if (grant) hold_q <= '0;
`ifdef BID_ESCALATE_EN
          if (esc_tick && ({1'b0, bid_q} < BID_CAP)) bid_q <= bid_esc;
`endif
        end
        XFER: begin
          if (!grant) begin
            if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
          end else if (hold_last) begin
            if (!rw_q) rdata_q <= DataFromSlave;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bid_master_ctrl.sv
// ============================================================================
//  Module  : tb_bid_master_ctrl
//  Brief   : Directed self-checking bench for bid_master_ctrl.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bid_master_ctrl;
  import bid_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr, cmd_wdata, cmd_bid;
  logic        xfr, grant, RW;
  logic [31:0] req, addr, DataToSlave, DataFromSlave;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_retry;

  int vectors = 0;
  int miscompares = 0;

  bid_master_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rw        (cmd_rw),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_bid       (cmd_bid),
    .xfr           (xfr),
    .req           (req),
    .grant         (grant),
    .addr          (addr),
    .RW            (RW),
    .DataToSlave   (DataToSlave),
    .DataFromSlave (DataFromSlave),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_retry     (rsp_retry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_bid = b;
    for (int i = 0; i < 64 && cmd_ready !== 1'b1; i++) tick();
    if (cmd_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: cmd_ready=%b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_xfr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (xfr === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic grant_until_rsp(input logic [31:0] d, output bit ok, output logic [31:0] rd, output logic [7:0] rt);
    ok = 1'b0; rd = '0; rt = '0;
    grant = 1'b1; DataFromSlave = d;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin ok = 1'b1; rd = rsp_rdata; rt = rsp_retry; break; end
    end
    grant = 1'b0; DataFromSlave = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    vectors++; if (xfr !== 1'b0) begin miscompares++; $display("FAIL reset_xfr: got %b expected 0", xfr); end
    vectors++; if (req !== 32'd0) begin miscompares++; $display("FAIL reset_req: got %0d expected 0", req); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", addr); end
  endtask

  task automatic test_write_basic();
    push_cmd(1'b1, C_M0_S0, 32'd5, 32'd10);
    vectors++; if (xfr !== 1'b0) begin miscompares++; $display("FAIL t1_idle_xfr: got %b expected 0", xfr); end
    tick();
    vectors++; if (xfr !== 1'b1 || req !== 32'd10) begin miscompares++; $display("FAIL t1_req: xfr=%b req=%0d expected 1/10", xfr, req); end
    vectors++; if (addr !== 32'hFFEF_0200 || RW !== 1'b1 || DataToSlave !== 32'd5) begin
      miscompares++; $display("FAIL t1_bus: addr=%h RW=%b data=%0d expected FFEF0200/1/5", addr, RW, DataToSlave); end
    tick(); tick();
    grant = 1'b1;
    tick();
    vectors++; if (xfr !== 1'b1 || req !== 32'd10 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL t1_xfer1: xfr=%b req=%0d rsp=%b expected 1/10/0", xfr, req, rsp_valid); end
    tick();
    vectors++; if (req !== 32'd10 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL t1_xfer2: req=%0d rsp=%b expected 10/0", req, rsp_valid); end
    tick();
    vectors++; if (rsp_valid !== 1'b1 || xfr !== 1'b0 || req !== 32'd0 || rsp_rdata !== 32'd0 || rsp_retry !== 8'd0) begin
      miscompares++; $display("FAIL t1_done: rsp=%b xfr=%b req=%0d rdata=%h retry=%0d expected 1/0/0/0/0",
                              rsp_valid, xfr, req, rsp_rdata, rsp_retry); end
    grant = 1'b0;
    tick();
    vectors++; if (rsp_valid !== 1'b0 || xfr !== 1'b0) begin
      miscompares++; $display("FAIL t1_after: rsp=%b xfr=%b expected 0/0", rsp_valid, xfr); end
  endtask

  task automatic test_read_data();
    bit ok; logic [31:0] rd; logic [7:0] rt;
    push_cmd(1'b0, C_M0_S1, 32'h1111, 32'd20);
    push_cmd(1'b1, C_M0_S2, 32'h2222, 32'd20);
    wait_xfr(ok);
    vectors++; if (!ok || RW !== 1'b0 || addr !== 32'hFFEF_1200) begin
      miscompares++; $display("FAIL t2_read_req: ok=%b RW=%b addr=%h expected 1/0/FFEF1200", ok, RW, addr); end
    grant_until_rsp(32'hDEAD, ok, rd, rt);
    vectors++; if (!ok || rd !== 32'hDEAD) begin miscompares++; $display("FAIL t2_rdata: ok=%b got %h expected DEAD", ok, rd); end
    tick();
    vectors++; if (xfr !== 1'b0) begin miscompares++; $display("FAIL t2_gap: xfr=%b expected 0", xfr); end
    wait_xfr(ok);
    grant_until_rsp(32'hBEEF, ok, rd, rt);
    vectors++; if (!ok || rd !== 32'd0) begin miscompares++; $display("FAIL t2_wr_rdata: ok=%b got %h expected 0", ok, rd); end
    tick();
  endtask

  task automatic test_fifo_full();
    bit ok; logic [31:0] rd; logic [7:0] rt;
    logic [31:0] exp_a [5];
    exp_a[0] = C_M0_S0; exp_a[1] = C_M0_S1; exp_a[2] = C_M0_S2; exp_a[3] = C_M0_S3; exp_a[4] = slave_addr(4'd1, 4'd0);
    push_cmd(1'b1, C_M0_S3, 32'h99, 32'd3);
    wait_xfr(ok);
    for (int k = 0; k < 4; k++) push_cmd(1'b1, exp_a[k], 32'h100 + k, 32'd3);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL t3_full: cmd_ready=%b expected 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = exp_a[4]; cmd_wdata = 32'h104; cmd_bid = 32'd3;
    grant_until_rsp(32'h0, ok, rd, rt);
    vectors++; if (!ok || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL t3_done_full: ok=%b cmd_ready=%b expected 1/0", ok, cmd_ready); end
    tick();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL t3_pop_ready: cmd_ready=%b expected 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL t3_refull: cmd_ready=%b expected 0", cmd_ready); end
    for (int k = 0; k < 5; k++) begin
      wait_xfr(ok);
      vectors++; if (!ok || addr !== exp_a[k] || DataToSlave !== 32'h100 + k) begin
        miscompares++; $display("FAIL t3_order%0d: addr=%h data=%h expected %h/%h", k, addr, DataToSlave, exp_a[k], 32'h100 + k); end
      grant_until_rsp(32'h0, ok, rd, rt);
      tick();
    end
  endtask

  task automatic test_retry();
    bit ok; logic [31:0] rd; logic [7:0] rt;
    push_cmd(1'b1, C_M0_S2, 32'h7, 32'd42);
    wait_xfr(ok);
    grant = 1'b1; tick(); tick();
    grant = 1'b0; tick();
    vectors++; if (xfr !== 1'b1 || rsp_valid !== 1'b0 || req !== 32'd42) begin
      miscompares++; $display("FAIL t4_back_to_req: xfr=%b rsp=%b req=%0d expected 1/0/42", xfr, rsp_valid, req); end
    tick(); tick();
    grant_until_rsp(32'h0, ok, rd, rt);
    vectors++; if (!ok || rt !== 8'd1) begin miscompares++; $display("FAIL t4_retry: ok=%b got %0d expected 1", ok, rt); end
    tick();
  endtask

  task automatic test_escalate();
    bit ok; logic [31:0] rd; logic [7:0] rt;
    logic [31:0] exp [4];
`ifdef BID_ESCALATE_EN
    exp[0] = 32'd250; exp[1] = 32'd254; exp[2] = 32'd255; exp[3] = 32'd255;
`else
    exp[0] = 32'd250; exp[1] = 32'd250; exp[2] = 32'd250; exp[3] = 32'd250;
`endif
    push_cmd(1'b0, C_M0_S1, 32'h0, 32'd250);
    wait_xfr(ok);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (!ok || req !== exp[k]) begin miscompares++; $display("FAIL t5_bid%0d: got %0d expected %0d", k, req, exp[k]); end
      if (k < 3) for (int j = 0; j < 8; j++) tick();
    end
    grant_until_rsp(32'h5, ok, rd, rt);
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen; logic [31:0] rd; logic [7:0] rt;
    push_cmd(1'b1, C_M0_S0, 32'h1, 32'd7);
    wait_xfr(ok);
    push_cmd(1'b1, C_M0_S1, 32'h2, 32'd7);
    push_cmd(1'b1, C_M0_S2, 32'h3, 32'd7);
    grant = 1'b1; tick();
    rst = 1'b1; tick();
    seen = rsp_valid;
    vectors++; if (xfr !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || req !== 32'd0) begin
      miscompares++; $display("FAIL t6_rst: xfr=%b ready=%b rsp=%b req=%0d expected 0/1/0/0", xfr, cmd_ready, rsp_valid, req); end
    rst = 1'b0; grant = 1'b0;
    tick(); seen |= rsp_valid; tick(); seen |= rsp_valid;
    vectors++; if (xfr !== 1'b0 || seen !== 1'b0) begin
      miscompares++; $display("FAIL t6_flushed: xfr=%b rsp_seen=%b expected 0/0", xfr, seen); end
    push_cmd(1'b1, C_M0_S3, 32'h4, 32'd0);
    wait_xfr(ok);
    vectors++; if (!ok || req !== 32'd1) begin miscompares++; $display("FAIL t6_bid0: got %0d expected 1", req); end
    grant_until_rsp(32'h0, ok, rd, rt);
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_bid = '0;
    grant = 1'b0; DataFromSlave = '0;
    test_reset();
    test_write_basic();
    test_read_data();
    test_fifo_full();
    test_retry();
    test_escalate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
